// File: rtl/noc_packet_sink.sv
// NoC packet sink: accepts flits, checks header/body/tail framing, destination and
// payload sequence, and keeps good/bad packet counters plus sticky error flags.
module noc_packet_sink #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned X_ID   = 1,
  parameter int unsigned Y_ID   = 1
) (
  input  logic              noc_clk,
  input  logic              noc_rst_n,
  input  logic              receive_valid,
  output logic              receive_ready,
  input  logic [DATA_W-1:0] receive_flit,
  input  logic              receive_is_header,
  input  logic              receive_is_tail,
  input  logic              sink_stall,
  output logic [7:0]        receive_num,
  output logic [7:0]        err_num,
  output logic [3:0]        err_flags,
  output logic [7:0]        last_src
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned F_DEST  = 0;
  localparam int unsigned F_SEQ   = 1;
  localparam int unsigned F_LEN   = 2;
  localparam int unsigned F_PROTO = 3;

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_DRAIN} state_t;

  state_t              state, state_nxt;
  logic                xfer;
  logic [ID_W-1:0]     hdr_dest_x, hdr_dest_y;
  logic [CNT_W-1:0]    hdr_src, hdr_len;
  logic                dest_ok, payload_ok, last_body, hdr_resolves;
  logic [FLAG_W-1:0]   hdr_flags, load_flags;

  logic [CNT_W-1:0]    idx, len_r, src_r;
  logic [FLAG_W-1:0]   pkt_flags;

  logic                res_valid, abort_valid, load_hdr, idx_step;
  logic [FLAG_W-1:0]   res_flags, abort_flags;
  logic [CNT_W-1:0]    res_src;
  logic [1:0]          bad_inc;
  logic [CNT_W:0]      err_sum;
  logic [CNT_W-1:0]    err_num_nxt;

  assign receive_ready = !sink_stall && noc_rst_n;
  assign xfer          = receive_valid && receive_ready;

  assign hdr_dest_x   = receive_flit[DATA_W-1 -: ID_W];
  assign hdr_dest_y   = receive_flit[DATA_W-5 -: ID_W];
  assign hdr_src      = receive_flit[DATA_W-9 -: CNT_W];
  assign hdr_len      = receive_flit[CNT_W-1:0];
  assign dest_ok      = (hdr_dest_x == ID_W'(X_ID)) && (hdr_dest_y == ID_W'(Y_ID));
  assign payload_ok   = (receive_flit == DATA_W'(idx));
  assign last_body    = (idx == len_r - CNT_W'(1));
  // A header finishes its packet on the spot when it is also the tail or announces no body.
  assign hdr_resolves = receive_is_tail || (hdr_len == '0);

  always_comb begin
    hdr_flags          = '0;
    load_flags         = '0;
    hdr_flags[F_DEST]  = !dest_ok;
    hdr_flags[F_LEN]   = receive_is_tail ? (hdr_len != '0) : 1'b1;
    load_flags[F_DEST] = !dest_ok;
  end

  // State register
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; a header restarts framing from any state
  always_comb begin
    state_nxt = state;
    if (xfer) begin
      if (receive_is_header) begin
        if (receive_is_tail)        state_nxt = S_IDLE;
        else if (hdr_len != '0)     state_nxt = S_BODY;
        else                        state_nxt = S_DRAIN;
      end else begin
        case (state)
          S_IDLE:  if (!receive_is_tail) state_nxt = S_DRAIN;
          S_BODY: begin
            if (receive_is_tail)    state_nxt = S_IDLE;
            else if (last_body)     state_nxt = S_DRAIN;
          end
          S_DRAIN: if (receive_is_tail) state_nxt = S_IDLE;
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Packet outcome events: abort kills the packet in flight, res resolves the current one
  always_comb begin
    res_valid   = 1'b0;
    res_flags   = '0;
    res_src     = hdr_src;
    abort_valid = 1'b0;
    abort_flags = '0;
    load_hdr    = 1'b0;
    idx_step    = 1'b0;
    if (xfer) begin
      if (receive_is_header) begin
        if (state == S_BODY) begin
          abort_valid          = 1'b1;
          abort_flags          = pkt_flags;
          abort_flags[F_PROTO] = 1'b1;
        end
        if (hdr_resolves) begin
          res_valid = 1'b1;
          res_flags = hdr_flags;
        end else begin
          load_hdr  = 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            abort_valid          = 1'b1;
            abort_flags[F_PROTO] = 1'b1;
          end
          S_BODY: begin
            if (receive_is_tail || last_body) begin
              res_valid        = 1'b1;
              res_src          = src_r;
              res_flags        = pkt_flags;
              res_flags[F_SEQ] = pkt_flags[F_SEQ] | !payload_ok;
              res_flags[F_LEN] = receive_is_tail ? !last_body : 1'b1;
            end else begin
              idx_step = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Per-packet context
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      idx       <= '0;
      len_r     <= '0;
      src_r     <= '0;
      pkt_flags <= '0;
    end else if (load_hdr) begin
      idx       <= '0;
      len_r     <= hdr_len;
      src_r     <= hdr_src;
      pkt_flags <= load_flags;
    end else if (idx_step) begin
      idx            <= idx + CNT_W'(1);
      pkt_flags[F_SEQ] <= pkt_flags[F_SEQ] | !payload_ok;
    end
  end

  // Up to two bad packets can close in one cycle (aborted body plus a bad one-flit header)
  always_comb begin
    bad_inc     = 2'(abort_valid) + 2'(res_valid && (res_flags != '0));
    err_sum     = (CNT_W+1)'(err_num) + (CNT_W+1)'(bad_inc);
    err_num_nxt = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  end

  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      receive_num <= '0;
      err_num     <= '0;
      err_flags   <= '0;
      last_src    <= '0;
    end else begin
      if (res_valid && (res_flags == '0)) begin
        receive_num <= receive_num + CNT_W'(1);
        last_src    <= res_src;
      end
      err_num   <= err_num_nxt;
      err_flags <= err_flags | abort_flags | res_flags;
    end
  end

endmodule

// File: tb/tb_noc_packet_sink.sv
// Directed bench for noc_packet_sink: framing, destination, sequence and counter edge cases.
module tb_noc_packet_sink;

  logic        noc_clk;
  logic        noc_rst_n;
  logic        receive_valid;
  logic        receive_ready;
  logic [31:0] receive_flit;
  logic        receive_is_header;
  logic        receive_is_tail;
  logic        sink_stall;
  logic [7:0]  receive_num;
  logic [7:0]  err_num;
  logic [3:0]  err_flags;
  logic [7:0]  last_src;

  int unsigned n_cmp;
  int unsigned n_bad;
  logic        toggle_stall;

  noc_packet_sink #(.DATA_W(32), .X_ID(1), .Y_ID(1)) dut (
    .noc_clk           (noc_clk),
    .noc_rst_n         (noc_rst_n),
    .receive_valid     (receive_valid),
    .receive_ready     (receive_ready),
    .receive_flit      (receive_flit),
    .receive_is_header (receive_is_header),
    .receive_is_tail   (receive_is_tail),
    .sink_stall        (sink_stall),
    .receive_num       (receive_num),
    .err_num           (err_num),
    .err_flags         (err_flags),
    .last_src          (last_src)
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [3:0] dx, input logic [3:0] dy,
                                      input logic [3:0] sx, input logic [3:0] sy,
                                      input logic [7:0] len);
    return {dx, dy, sx, sy, 8'h00, len};
  endfunction

  // Called at a falling edge; returns at a falling edge after the flit was accepted.
  task automatic send(input logic [31:0] f, input logic h, input logic t);
    int unsigned waits;
    logic        accepted;
    receive_valid     = 1'b1;
    receive_flit      = f;
    receive_is_header = h;
    receive_is_tail   = t;
    waits    = 0;
    accepted = 1'b0;
    while (!accepted && waits < 20) begin
      @(posedge noc_clk);
      waits++;
      accepted = receive_ready;
      @(negedge noc_clk);
      if (toggle_stall) sink_stall = ~sink_stall;
    end
    if (!accepted) check_eq("send_timeout", 32'(accepted), 32'd1);
    receive_valid     = 1'b0;
    receive_is_header = 1'b0;
    receive_is_tail   = 1'b0;
  endtask

  task automatic do_reset();
    noc_rst_n = 1'b0;
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] rn, input logic [7:0] en,
                            input logic [3:0] fl, input logic [7:0] src);
    check_eq({tag, "_rnum"},  32'(receive_num), 32'(rn));
    check_eq({tag, "_enum"},  32'(err_num),     32'(en));
    check_eq({tag, "_flags"}, 32'(err_flags),   32'(fl));
    check_eq({tag, "_src"},   32'(last_src),    32'(src));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    toggle_stall      = 1'b0;
    noc_rst_n         = 1'b0;
    receive_valid     = 1'b0;
    receive_flit      = '0;
    receive_is_header = 1'b0;
    receive_is_tail   = 1'b0;
    sink_stall        = 1'b0;
    repeat (2) @(negedge noc_clk);

    check_eq("rst_ready", 32'(receive_ready), 32'd0);
    check_outs("rst", 8'd0, 8'd0, 4'b0000, 8'h00);
    noc_rst_n = 1'b1;
    #1;
    check_eq("ready_idle", 32'(receive_ready), 32'd1);
    sink_stall = 1'b1;
    #1;
    check_eq("ready_stall", 32'(receive_ready), 32'd0);
    sink_stall = 1'b0;
    @(negedge noc_clk);

    // Basic good packet, back-to-back
    send(hdr(4'd1, 4'd1, 4'd0, 4'd0, 8'd3), 1'b1, 1'b0);
    send(32'd0, 1'b0, 1'b0);
    send(32'd1, 1'b0, 1'b0);
    send(32'd2, 1'b0, 1'b1);
    check_outs("good", 8'd1, 8'd0, 4'b0000, 8'h00);

    // Same shape under alternating backpressure
    sink_stall   = 1'b1;
    toggle_stall = 1'b1;
    send(hdr(4'd1, 4'd1, 4'd2, 4'd3, 8'd3), 1'b1, 1'b0);
    send(32'd0, 1'b0, 1'b0);
    send(32'd1, 1'b0, 1'b0);
    send(32'd2, 1'b0, 1'b1);
    toggle_stall = 1'b0;
    sink_stall   = 1'b0;
    check_outs("stall", 8'd2, 8'd0, 4'b0000, 8'h23);

    // Wrong destination, then a good packet
    send(hdr(4'd0, 4'd1, 4'd4, 4'd5, 8'd2), 1'b1, 1'b0);
    send(32'd0, 1'b0, 1'b0);
    send(32'd1, 1'b0, 1'b1);
    check_outs("dest", 8'd2, 8'd1, 4'b0001, 8'h23);
    send(hdr(4'd1, 4'd1, 4'd6, 4'd7, 8'd1), 1'b1, 1'b0);
    send(32'd0, 1'b0, 1'b1);
    check_outs("dest_good", 8'd3, 8'd1, 4'b0001, 8'h67);

    // Sequence error, then early tail
    do_reset();
    send(hdr(4'd1, 4'd1, 4'd0, 4'd0, 8'd3), 1'b1, 1'b0);
    send(32'd0, 1'b0, 1'b0);
    send(32'd5, 1'b0, 1'b0);
    send(32'd2, 1'b0, 1'b1);
    check_outs("seq", 8'd0, 8'd1, 4'b0010, 8'h00);
    send(hdr(4'd1, 4'd1, 4'd0, 4'd0, 8'd4), 1'b1, 1'b0);
    send(32'd0, 1'b0, 1'b1);
    check_outs("len_short", 8'd0, 8'd2, 4'b0110, 8'h00);

    // Body flit in IDLE, drained up to its tail, then a one-flit good packet
    do_reset();
    send(32'd0, 1'b0, 1'b0);
    check_outs("proto_idle", 8'd0, 8'd1, 4'b1000, 8'h00);
    send(32'd1, 1'b0, 1'b0);
    send(32'd2, 1'b0, 1'b1);
    send(hdr(4'd1, 4'd1, 4'd8, 4'd9, 8'd0), 1'b1, 1'b1);
    check_outs("proto_recover", 8'd1, 8'd1, 4'b1000, 8'h89);

    // Header interrupting a body: old packet bad, new one-flit packet good in the same cycle
    do_reset();
    send(hdr(4'd1, 4'd1, 4'd1, 4'd1, 8'd3), 1'b1, 1'b0);
    send(32'd0, 1'b0, 1'b0);
    send(hdr(4'd1, 4'd1, 4'd2, 4'd2, 8'd0), 1'b1, 1'b1);
    check_outs("hdr_in_body", 8'd1, 8'd1, 4'b1000, 8'h22);

    // Missing tail at the last index: bad at once, rest drained
    send(hdr(4'd1, 4'd1, 4'd0, 4'd0, 8'd2), 1'b1, 1'b0);
    send(32'd0, 1'b0, 1'b0);
    send(32'd1, 1'b0, 1'b0);
    check_outs("len_long", 8'd1, 8'd2, 4'b1100, 8'h22);
    send(32'd7, 1'b0, 1'b1);
    check_outs("drain", 8'd1, 8'd2, 4'b1100, 8'h22);
    send(hdr(4'd1, 4'd1, 4'd3, 4'd3, 8'd0), 1'b1, 1'b1);
    check_outs("after_drain", 8'd2, 8'd2, 4'b1100, 8'h33);

    // Longest legal body
    do_reset();
    send(hdr(4'd1, 4'd1, 4'd0, 4'd5, 8'd255), 1'b1, 1'b0);
    for (int k = 0; k < 255; k++) send(32'(k), 1'b0, (k == 254));
    check_outs("len255", 8'd1, 8'd0, 4'b0000, 8'h05);

    // Counter wrap and saturation
    do_reset();
    for (int i = 0; i < 255; i++) send(hdr(4'd1, 4'd1, 4'd1, 4'd2, 8'd0), 1'b1, 1'b1);
    check_eq("rnum_255", 32'(receive_num), 32'd255);
    send(hdr(4'd1, 4'd1, 4'd1, 4'd2, 8'd0), 1'b1, 1'b1);
    check_outs("wrap", 8'd0, 8'd0, 4'b0000, 8'h12);
    for (int i = 0; i < 300; i++) send(hdr(4'd0, 4'd0, 4'd0, 4'd0, 8'd0), 1'b1, 1'b1);
    check_outs("sat", 8'd0, 8'd255, 4'b0001, 8'h12);

    // Reset in the middle of a packet
    send(hdr(4'd1, 4'd1, 4'd4, 4'd4, 8'd3), 1'b1, 1'b0);
    send(32'd0, 1'b0, 1'b0);
    noc_rst_n = 1'b0;
    @(negedge noc_clk);
    check_eq("midrst_ready", 32'(receive_ready), 32'd0);
    check_outs("midrst", 8'd0, 8'd0, 4'b0000, 8'h00);
    noc_rst_n = 1'b1;
    send(32'd1, 1'b0, 1'b0);
    check_outs("post_rst", 8'd0, 8'd1, 4'b1000, 8'h00);
    send(32'd2, 1'b0, 1'b1);
    send(hdr(4'd1, 4'd1, 4'd7, 4'd1, 8'd0), 1'b1, 1'b1);
    check_outs("post_rst_good", 8'd1, 8'd1, 4'b1000, 8'h71);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
